fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch unit.
// Build option: FETCH_HALT_EN adds the HALT state (and the halted port on fetch_unit).
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 4;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } fetch_state_e;
`endif

  // Width of an occupancy counter that must be able to hold the value depth itself
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with synchronous push, pop and flush.
// Flush wins over push/pop; push into a full buffer is only accepted with a same-cycle pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next pointers, occupancy and storage contents from the push/pop/flush requests
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset empties the buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while count says they are not live
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, one-cycle-latency memory requests,
// buffering of returned words and presentation of the buffer head to decode.
// Build option: FETCH_HALT_EN stops fetching after an all-ones word and adds the halted port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_HALT_EN
  ,
  output logic              halted
`endif
);

  localparam int CNT_W   = count_width(DEPTH);
  localparam int ENTRY_W = ADDR_W + 32;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       head_word;

  assign fifo_empty = (fifo_count == '0);
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign head_word  = head_entry[31:0];
  assign head_pc    = head_entry[ENTRY_W-1:32];
  assign imem_addr  = pc_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == HALT);
`endif

  // Each buffer entry carries the returned word tagged with the address it was fetched from
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({inflight_pc_q, imem_data}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  // Decode-side view: buffer head when available, otherwise a NOP bubble at the last shown PC
  always_comb begin
    instruction = NOP_INSTR;
    instr_valid = 1'b0;
    instr_pc    = last_pc_q;
    if (!fifo_empty) begin
      instruction = head_word;
      instr_valid = 1'b1;
      instr_pc    = head_pc;
    end
  end

  // Request issue, buffer control and next PC/state; a redirect overrides everything else
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    last_pc_d     = fifo_empty ? last_pc_q : head_pc;
    imem_req      = 1'b0;
    fifo_push     = inflight_q && !redirect_valid;
    fifo_pop      = !fifo_empty && !stall && !redirect_valid;
    fifo_flush    = redirect_valid;

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (rst && !redirect_valid && (occupancy < DEPTH_OCC)) begin
          imem_req = 1'b1;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase

    if (imem_req) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

`ifdef FETCH_HALT_EN
    if (fifo_push && (imem_data == HALT_INSTR)) begin
      state_d = HALT;
    end
`endif

    if (redirect_valid) begin
      pc_d = redirect_pc;
`ifdef FETCH_HALT_EN
      if (state_q == HALT) begin
        state_d = RUN;
      end
`endif
    end
  end

  // State registers; reset drops any in-flight response and returns to IDLE at PC 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      last_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      last_pc_q     <= last_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream
// checked against a counting model of requests issued and instructions consumed.
// Build option: FETCH_HALT_EN enables the halt scenario.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic [AW-1:0] instr_pc;
`ifdef FETCH_HALT_EN
  logic          halted;
`endif

  logic [31:0]   mem [1024];
  int            n_cmp  = 0;
  int            n_fail = 0;

  // Model: next address to be requested, next address to be consumed, last shown PC
  logic [AW-1:0] m_req_pc;
  logic [AW-1:0] m_out_pc;
  logic [AW-1:0] m_shown;
  logic          m_last_req;
  logic          m_run;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc)
`ifdef FETCH_HALT_EN
    ,
    .halted         (halted)
`endif
  );

  // Instruction memory: data one cycle after a request, junk otherwise
  always @(posedge clk) begin
    imem_data <= imem_req ? mem[imem_addr] : $urandom;
  end

  task automatic drive(input logic r, input logic s, input logic rv, input logic [AW-1:0] rp);
    @(negedge clk);
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
  endtask

  task automatic run_cycle(input logic s);
    drive(1'b1, s, 1'b0, '0);
  endtask

  function automatic int outstanding();
    logic [AW-1:0] d;
    d = m_req_pc - m_out_pc;
    return int'(d);
  endfunction

  function automatic logic exp_valid();
    return (outstanding() - int'(m_last_req)) > 0;
  endfunction

  function automatic logic exp_req();
    return m_run && rst && !redirect_valid && (outstanding() < DEPTH);
  endfunction

  // Advance the model across the coming clock edge using this cycle's inputs
  task automatic advance();
    logic v;
    v = exp_valid();
    if (!rst) begin
      m_req_pc = '0; m_out_pc = '0; m_shown = '0; m_last_req = 1'b0; m_run = 1'b0;
    end else if (redirect_valid) begin
      if (v) m_shown = m_out_pc;
      m_req_pc = redirect_pc; m_out_pc = redirect_pc; m_last_req = 1'b0; m_run = 1'b1;
    end else begin
      if (v) m_shown = m_out_pc;
      if (imem_req) m_req_pc = m_req_pc + AW'(1);
      m_last_req = imem_req;
      if (v && !stall) m_out_pc = m_out_pc + AW'(1);
      m_run = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, '0); advance();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++; if (imem_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 000", imem_addr); end
    n_cmp++; if (instruction !== NOP_INSTR) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instruction); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr_pc !== '0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 000", instr_pc); end
    advance();
  endtask

  task automatic test_first_fetch();
    run_cycle(1'b0);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_req: got %b expected 0", imem_req); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL first_req: got %b@%h expected 1@000", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL first_valid0: got %b expected 0", instr_valid); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h001) begin n_fail++; $display("[TB] FAIL second_req: got %b@%h expected 1@001", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL first_valid1: got %b expected 0", instr_valid); end
    advance();
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0);
      n_cmp++;
      if (instr_valid !== 1'b1 || instruction !== 32'h100 + 32'(k) || instr_pc !== AW'(k)) begin
        n_fail++;
        $display("[TB] FAIL stream_%0d: got %b %h@%h expected 1 %h@%h", k, instr_valid, instruction, instr_pc, 32'h100 + 32'(k), AW'(k));
      end
      advance();
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0]   s_ins;
    logic [AW-1:0] s_pc;
    logic [AW-1:0] e_pc;
    run_cycle(1'b1);
    s_ins = instruction;
    s_pc  = instr_pc;
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_start_valid: got %b expected 1", instr_valid); end
    advance();
    for (int i = 1; i < 6; i++) begin
      run_cycle(1'b1);
      n_cmp++;
      if (instr_valid !== 1'b1 || instruction !== s_ins || instr_pc !== s_pc) begin
        n_fail++;
        $display("[TB] FAIL stall_hold_%0d: got %b %h@%h expected 1 %h@%h", i, instr_valid, instruction, instr_pc, s_ins, s_pc);
      end
      n_cmp++; if (imem_req !== exp_req()) begin n_fail++; $display("[TB] FAIL stall_req_%0d: got %b expected %b", i, imem_req, exp_req()); end
      if (i >= 3) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_full_%0d: got %b expected 0", i, imem_req); end
      end
      advance();
    end
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0);
      e_pc = s_pc + AW'(k);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== e_pc || instruction !== mem[e_pc]) begin
        n_fail++;
        $display("[TB] FAIL after_stall_%0d: got %b %h@%h expected 1 %h@%h", k, instr_valid, instruction, instr_pc, mem[e_pc], e_pc);
      end
      advance();
    end
  endtask

  task automatic test_redirect_wrap();
    logic [AW-1:0] old_pc;
    logic [AW-1:0] e_pc;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b1); advance();
    end
    drive(1'b1, 1'b1, 1'b1, 10'h3FE);
    old_pc = instr_pc;
    n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_valid: got %b expected 1", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL redirect_req: got %b expected 0", imem_req); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (instr_valid !== 1'b0 || instr_pc !== old_pc) begin n_fail++; $display("[TB] FAIL flush_out: got %b@%h expected 0@%h", instr_valid, instr_pc, old_pc); end
    advance();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        e_pc = 10'h3FE + AW'(k);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== e_pc) begin n_fail++; $display("[TB] FAIL wrap_req_%0d: got %b@%h expected 1@%h", k, imem_req, imem_addr, e_pc); end
      end
      if (k >= 2) begin
        e_pc = 10'h3FE + AW'(k - 2);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== e_pc || instruction !== mem[e_pc]) begin
          n_fail++;
          $display("[TB] FAIL wrap_out_%0d: got %b %h@%h expected 1 %h@%h", k, instr_valid, instruction, instr_pc, mem[e_pc], e_pc);
        end
      end else begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_gap_%0d: got %b expected 0", k, instr_valid); end
      end
      advance();
      run_cycle(1'b0);
    end
    advance();
  endtask

  task automatic test_redirect_stall_inflight();
    int found;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      run_cycle(1'b0);
      if (imem_req === 1'b1) found = 1;
      advance();
    end
    n_cmp++; if (found == 0) begin n_fail++; $display("[TB] FAIL inflight_wait: got no request expected one within 10 cycles"); end
    drive(1'b1, 1'b1, 1'b1, 10'h020);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rs_req: got %b expected 0", imem_req); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h020) begin n_fail++; $display("[TB] FAIL rs_first: got %b %b@%h expected 0 1@020", instr_valid, imem_req, imem_addr); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rs_discard: got %b %h@%h expected 0", instr_valid, instruction, instr_pc); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 10'h020 || instruction !== 32'h120) begin n_fail++; $display("[TB] FAIL rs_resume: got %b %h@%h expected 1 00000120@020", instr_valid, instruction, instr_pc); end
    advance();
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0); advance();
    end
    drive(1'b0, 1'b0, 1'b0, '0); advance();
    run_cycle(1'b0);
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== '0 || instruction !== NOP_INSTR || instr_valid !== 1'b0 || instr_pc !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_out: got req=%b addr=%h ins=%h v=%b pc=%h expected all zero", imem_req, imem_addr, instruction, instr_valid, instr_pc);
    end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL midreset_refetch: got %b@%h expected 1@000", imem_req, imem_addr); end
    advance();
    run_cycle(1'b0); advance();
    run_cycle(1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instruction !== 32'h100 || instr_pc !== 10'h000) begin n_fail++; $display("[TB] FAIL midreset_first: got %b %h@%h expected 1 00000100@000", instr_valid, instruction, instr_pc); end
    advance();
  endtask

`ifndef FETCH_HALT_EN
  task automatic test_ones_ordinary();
    int seen;
    seen = 0;
    mem[10'h040] = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b1, 10'h03C); advance();
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b0);
      n_cmp++; if (imem_req !== exp_req()) begin n_fail++; $display("[TB] FAIL ones_req_%0d: got %b expected %b", k, imem_req, exp_req()); end
      if (exp_valid()) begin
        n_cmp++; if (instruction !== mem[m_out_pc] || instr_pc !== m_out_pc) begin n_fail++; $display("[TB] FAIL ones_out_%0d: got %h@%h expected %h@%h", k, instruction, instr_pc, mem[m_out_pc], m_out_pc); end
        if (instruction === 32'hFFFF_FFFF) seen++;
      end
      advance();
    end
    n_cmp++; if (seen != 1) begin n_fail++; $display("[TB] FAIL ones_seen: got %0d expected 1", seen); end
    n_cmp++; if (m_req_pc < 10'h045) begin n_fail++; $display("[TB] FAIL ones_continue: got next req %h expected >= 045", m_req_pc); end
    mem[10'h040] = 32'h140;
  endtask
`endif

  task automatic test_random_stream();
    logic          r_i, s_i, rv_i;
    logic [AW-1:0] rp_i;
    for (int c = 0; c < 400; c++) begin
      r_i  = ($urandom_range(0, 99) != 0);
      s_i  = ($urandom_range(0, 3) == 0);
      rv_i = r_i && ($urandom_range(0, 24) == 0);
      rp_i = AW'($urandom);
      drive(r_i, s_i, rv_i, rp_i);
      n_cmp++; if (imem_req !== exp_req()) begin n_fail++; $display("[TB] FAIL rand_req_%0d: got %b expected %b", c, imem_req, exp_req()); end
      if (imem_req === 1'b1) begin
        n_cmp++; if (imem_addr !== m_req_pc) begin n_fail++; $display("[TB] FAIL rand_addr_%0d: got %h expected %h", c, imem_addr, m_req_pc); end
      end
      n_cmp++; if (instr_valid !== exp_valid()) begin n_fail++; $display("[TB] FAIL rand_valid_%0d: got %b expected %b", c, instr_valid, exp_valid()); end
      if (exp_valid()) begin
        n_cmp++; if (instruction !== mem[m_out_pc] || instr_pc !== m_out_pc) begin n_fail++; $display("[TB] FAIL rand_head_%0d: got %h@%h expected %h@%h", c, instruction, instr_pc, mem[m_out_pc], m_out_pc); end
      end else begin
        n_cmp++; if (instruction !== NOP_INSTR || instr_pc !== m_shown) begin n_fail++; $display("[TB] FAIL rand_bubble_%0d: got %h@%h expected 00000000@%h", c, instruction, instr_pc, m_shown); end
      end
      advance();
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    int max_req;
    int seen;
    max_req = -1;
    seen    = 0;
    mem[5]  = HALT_INSTR;
    drive(1'b0, 1'b0, 1'b0, '0); advance();
    for (int c = 0; c < 30; c++) begin
      run_cycle(1'b0);
      if (imem_req === 1'b1 && int'(imem_addr) > max_req) max_req = int'(imem_addr);
      if (instr_valid === 1'b1 && instr_pc === 10'h005) begin
        seen = 1;
        n_cmp++; if (instruction !== HALT_INSTR) begin n_fail++; $display("[TB] FAIL halt_word: got %h expected ffffffff", instruction); end
      end
      advance();
    end
    n_cmp++; if (seen == 0) begin n_fail++; $display("[TB] FAIL halt_delivered: got none expected word at 005"); end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halted_flag: got %b expected 1", halted); end
    n_cmp++; if (max_req != 6) begin n_fail++; $display("[TB] FAIL halt_last_req: got %0d expected 6", max_req); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_req: got %b expected 0", imem_req); end
    drive(1'b1, 1'b0, 1'b1, 10'h010);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_redirect_cycle: got %b expected 1", halted); end
    advance();
    run_cycle(1'b0);
    n_cmp++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h010) begin n_fail++; $display("[TB] FAIL halt_resume: got h=%b %b@%h expected h=0 1@010", halted, imem_req, imem_addr); end
    advance();
    run_cycle(1'b0); advance();
    run_cycle(1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instruction !== 32'h110 || instr_pc !== 10'h010) begin n_fail++; $display("[TB] FAIL halt_resume_out: got %b %h@%h expected 1 00000110@010", instr_valid, instruction, instr_pc); end
    advance();
    mem[5] = 32'h105;
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    m_req_pc = '0; m_out_pc = '0; m_shown = '0; m_last_req = 1'b0; m_run = 1'b0;
    $display("[TB] fetch_unit bench start");
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_redirect_wrap();
    test_redirect_stall_inflight();
    test_midstream_reset();
`ifndef FETCH_HALT_EN
    test_ones_ordinary();
`endif
    test_random_stream();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
